// File: rtl/star_delta_xform.sv
// Handshaked star<->delta resistor transformer with one shared restoring divider.
// Define STARDELTA_DELTA2STAR_EN to honour mode (delta->star); otherwise every set is star->delta.
module star_delta_xform #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [W-1:0] r_in0,
  input  logic [W-1:0] r_in1,
  input  logic [W-1:0] r_in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] r_out0,
  output logic [W-1:0] r_out1,
  output logic [W-1:0] r_out2,
  output logic         err,
  output logic         sat
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int CW = $clog2(2 * W);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * W - 1);
  localparam logic [2*W:0]  RES_MAX  = (2 * W + 1)'((1 << W) - 1);

  logic [2:0]     state;
  logic [W-1:0]   a0, a1, a2;
  logic           mode_r;
  logic [2*W-1:0] prod0, prod1, prod2;
  logic [W+1:0]   dvs0, dvs1, dvs2;
  logic [2*W-1:0] q0, q1, q2;
  logic [2*W-1:0] dvd, quo;
  logic [W+1:0]   rem;
  logic [1:0]     idx;
  logic [CW-1:0]  cnt;

  logic [2*W-1:0] p0, p1, p2;
  logic [W+1:0]   v0, v1, v2;

`ifdef STARDELTA_DELTA2STAR_EN
  logic [W+1:0] s_sum;
  assign s_sum = (W+2)'(a0) + (W+2)'(a1) + (W+2)'(a2);
  logic unused_mode;
  assign unused_mode = 1'b0;
`else
  logic unused_mode;
  assign unused_mode = mode ^ mode_r;
`endif

  // Product/divisor mapping for the three divisions, selected by the captured mode.
  always_comb begin
    p0 = (2*W)'(a0) * (2*W)'(a1);  v0 = (W+2)'(a2);
    p1 = (2*W)'(a1) * (2*W)'(a2);  v1 = (W+2)'(a0);
    p2 = (2*W)'(a2) * (2*W)'(a0);  v2 = (W+2)'(a1);
`ifdef STARDELTA_DELTA2STAR_EN
    if (mode_r) begin
      p0 = (2*W)'(a0) * (2*W)'(a2);
      p1 = (2*W)'(a0) * (2*W)'(a1);
      p2 = (2*W)'(a1) * (2*W)'(a2);
      v0 = s_sum;
      v1 = s_sum;
      v2 = s_sum;
    end
`endif
  end

  // One restoring step; a zero divisor always subtracts, so its quotient is naturally all ones.
  logic [W+1:0] cur_dvs;
  logic [W+2:0] trial, diff;
  logic         qbit;
  always_comb begin
    case (idx)
      2'd0:    cur_dvs = dvs0;
      2'd1:    cur_dvs = dvs1;
      default: cur_dvs = dvs2;
    endcase
    trial = {rem, dvd[2*W-1]};
    diff  = trial - {1'b0, cur_dvs};
    qbit  = (trial >= {1'b0, cur_dvs});
  end

  function automatic logic [2*W:0] form_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [2*W-1:0] q, input logic d2s);
    if (d2s) form_sum = (2*W+1)'(q);
    else     form_sum = (2*W+1)'(x) + (2*W+1)'(y) + (2*W+1)'(q);
  endfunction

  logic           d2s_act;
  logic [2*W:0]   sum0, sum1, sum2;
  logic           z0, z1, z2, ov0, ov1, ov2;
  always_comb begin
`ifdef STARDELTA_DELTA2STAR_EN
    d2s_act = mode_r;
`else
    d2s_act = 1'b0;
`endif
    sum0 = form_sum(a0, a1, q0, d2s_act);
    sum1 = form_sum(a1, a2, q1, d2s_act);
    sum2 = form_sum(a2, a0, q2, d2s_act);
    z0 = (dvs0 == '0);
    z1 = (dvs1 == '0);
    z2 = (dvs2 == '0);
    ov0 = sum0 > RES_MAX;
    ov1 = sum1 > RES_MAX;
    ov2 = sum2 > RES_MAX;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      r_out0 <= '0;
      r_out1 <= '0;
      r_out2 <= '0;
      err    <= 1'b0;
      sat    <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          a0     <= r_in0;
          a1     <= r_in1;
          a2     <= r_in2;
          mode_r <= mode;
          err    <= 1'b0;
          sat    <= 1'b0;
          state  <= S_LOAD;
        end
        S_LOAD: begin
          prod0 <= p0;  prod1 <= p1;  prod2 <= p2;
          dvs0  <= v0;  dvs1  <= v1;  dvs2  <= v2;
          dvd   <= p0;
          rem   <= '0;
          idx   <= '0;
          cnt   <= '0;
          state <= S_DIV;
        end
        S_DIV: begin
          quo <= {quo[2*W-2:0], qbit};
          if (cnt == CNT_LAST) begin
            case (idx)
              2'd0:    q0 <= {quo[2*W-2:0], qbit};
              2'd1:    q1 <= {quo[2*W-2:0], qbit};
              default: q2 <= {quo[2*W-2:0], qbit};
            endcase
            rem <= '0;
            cnt <= '0;
            dvd <= (idx == 2'd0) ? prod1 : prod2;
            idx <= idx + 2'd1;
            if (idx == 2'd2) state <= S_FIN;
          end else begin
            rem <= qbit ? diff[W+1:0] : trial[W+1:0];
            dvd <= {dvd[2*W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
          end
        end
        S_FIN: begin
          // Delta->star with S=0 yields zero outputs rather than a clamped all-ones quotient.
          if (d2s_act && z0) begin
            r_out0 <= '0;
            r_out1 <= '0;
            r_out2 <= '0;
          end else begin
            r_out0 <= ov0 ? RES_MAX[W-1:0] : sum0[W-1:0];
            r_out1 <= ov1 ? RES_MAX[W-1:0] : sum1[W-1:0];
            r_out2 <= ov2 ? RES_MAX[W-1:0] : sum2[W-1:0];
          end
          err   <= z0 | z1 | z2;
          sat   <= (ov0 & ~z0) | (ov1 & ~z1) | (ov2 & ~z2);
          state <= S_DONE;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_star_delta_xform.sv
// Self-checking bench for star_delta_xform (W=8): directed vectors, random sets against an
// arithmetic reference model, backpressure, mid-transaction reset and back-to-back traffic.
module tb_star_delta_xform;
  localparam int W = 8;
  localparam int LAT = 6 * W + 2;
  localparam int PW = 3 * W + 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, mode, out_valid, out_ready, err, sat;
  logic [W-1:0] r_in0, r_in1, r_in2, r_out0, r_out1, r_out2;

  int total = 0;
  int bad = 0;
  logic [PW-1:0] exp_q[$];

  star_delta_xform #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .r_in0(r_in0), .r_in1(r_in1), .r_in2(r_in2), .out_valid(out_valid), .out_ready(out_ready),
    .r_out0(r_out0), .r_out1(r_out1), .r_out2(r_out2), .err(err), .sat(sat)
  );

  always #5 clk = ~clk;

  // Reference model straight from the transformation formulas, in wide integer arithmetic.
  function automatic logic [PW-1:0] ref_model(input int unsigned x0, input int unsigned x1,
                                              input int unsigned x2, input logic md);
    longint unsigned v[3];
    longint unsigned r[3];
    longint unsigned maxv, s;
    logic e, st, d2s;
    v[0] = x0; v[1] = x1; v[2] = x2;
    maxv = (64'd1 << W) - 1;
    e = 1'b0; st = 1'b0;
`ifdef STARDELTA_DELTA2STAR_EN
    d2s = md;
`else
    d2s = md & 1'b0;
`endif
    if (d2s) begin
      s = v[0] + v[1] + v[2];
      if (s == 0) begin
        r[0] = 0; r[1] = 0; r[2] = 0; e = 1'b1;
      end else begin
        r[0] = v[0] * v[2] / s;
        r[1] = v[0] * v[1] / s;
        r[2] = v[1] * v[2] / s;
        for (int i = 0; i < 3; i++) if (r[i] > maxv) begin r[i] = maxv; st = 1'b1; end
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (v[(i + 2) % 3] == 0) begin
          r[i] = maxv; e = 1'b1;
        end else begin
          r[i] = v[i] + v[(i + 1) % 3] + v[i] * v[(i + 1) % 3] / v[(i + 2) % 3];
          if (r[i] > maxv) begin r[i] = maxv; st = 1'b1; end
        end
      end
    end
    ref_model = {r[0][W-1:0], r[1][W-1:0], r[2][W-1:0], e, st};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_accept(input logic [W-1:0] x0, input logic [W-1:0] x1,
                              input logic [W-1:0] x2, input logic md);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    in_valid = 1'b1; r_in0 = x0; r_in1 = x1; r_in2 = x2; mode = md;
    @(posedge clk); #1;
    in_valid = 1'b0;
    r_in0 = W'($urandom); r_in1 = W'($urandom); r_in2 = W'($urandom); mode = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = c; break; end
    end
  endtask

  task automatic take_output(output logic [PW-1:0] obs, output logic rdy_after,
                             output logic vld_after);
    obs = {r_out0, r_out1, r_out2, err, sat};
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    rdy_after = in_ready;
    vld_after = out_valid;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if ({r_out0, r_out1, r_out2, err, sat} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", {r_out0, r_out1, r_out2, err, sat});
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [W-1:0] vin[5][3];
    logic         vmd[5];
    logic [PW-1:0] vexp[5];
    logic [PW-1:0] obs;
    logic ra, va;
    int lat;
    vin[0] = '{8'd2, 8'd3, 8'd6};     vmd[0] = 1'b0; vexp[0] = {8'd6, 8'd18, 8'd12, 1'b0, 1'b0};
    vin[1] = '{8'd6, 8'd18, 8'd12};   vmd[1] = 1'b1;
`ifdef STARDELTA_DELTA2STAR_EN
    vexp[1] = {8'd2, 8'd3, 8'd6, 1'b0, 1'b0};
`else
    vexp[1] = {8'd33, 8'd66, 8'd22, 1'b0, 1'b0};
`endif
    vin[2] = '{8'd5, 8'd5, 8'd0};     vmd[2] = 1'b0; vexp[2] = {8'd255, 8'd5, 8'd5, 1'b1, 1'b0};
    vin[3] = '{8'd0, 8'd0, 8'd0};     vmd[3] = 1'b1;
`ifdef STARDELTA_DELTA2STAR_EN
    vexp[3] = {8'd0, 8'd0, 8'd0, 1'b1, 1'b0};
`else
    vexp[3] = {8'd255, 8'd255, 8'd255, 1'b1, 1'b0};
`endif
    vin[4] = '{8'd255, 8'd255, 8'd1}; vmd[4] = 1'b0; vexp[4] = {8'd255, 8'd255, 8'd255, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_accept(vin[i][0], vin[i][1], vin[i][2], vmd[i]);
      wait_valid(lat);
      total++;
      if (lat != LAT) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, LAT); end
      take_output(obs, ra, va);
      total++;
      if (obs !== vexp[i]) begin bad++; $display("FAIL directed%0d_result got=%h exp=%h", i, obs, vexp[i]); end
      total++;
      if (ra !== 1'b1 || va !== 1'b0) begin
        bad++; $display("FAIL directed%0d_release got rdy=%b vld=%b exp rdy=1 vld=0", i, ra, va);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] x[3];
    logic md;
    logic [PW-1:0] obs, e;
    logic ra, va;
    int lat;
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 5))
          0:       x[k] = '0;
          1:       x[k] = '1;
          default: x[k] = W'($urandom_range(1, 255));
        endcase
      end
      md = 1'($urandom);
      exp_q.push_back(ref_model(x[0], x[1], x[2], md));
      drive_accept(x[0], x[1], x[2], md);
      wait_valid(lat);
      total++;
      if (lat != LAT) begin bad++; $display("FAIL random%0d_latency got=%0d exp=%0d", n, lat, LAT); end
      take_output(obs, ra, va);
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++; $display("FAIL random%0d_result in=%0d,%0d,%0d md=%b got=%h exp=%h", n, x[0], x[1], x[2], md, obs, e);
      end
    end
  endtask

  task automatic test_backpressure;
    logic [PW-1:0] e;
    int lat, stray;
    e = ref_model(7, 9, 4, 1'b0);
    drive_accept(8'd7, 8'd9, 8'd4, 1'b0);
    wait_valid(lat);
    total++;
    if (lat != LAT) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", lat, LAT); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1; r_in0 = W'($urandom); r_in1 = W'($urandom); r_in2 = W'($urandom);
      @(posedge clk); #1;
      total++;
      if ({r_out0, r_out1, r_out2, err, sat} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h vld=%b rdy=%b exp=%h vld=1 rdy=0", c,
                 {r_out0, r_out1, r_out2, err, sat}, out_valid, in_ready, e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
    stray = 0;
    repeat (LAT + 10) begin @(posedge clk); #1; if (out_valid) stray++; end
    total++;
    if (stray != 0) begin bad++; $display("FAIL bp_ignored_input got=%0d exp=0 valid cycles", stray); end
  endtask

  task automatic test_reset_mid_div;
    logic [PW-1:0] obs;
    logic ra, va;
    int lat;
    drive_accept(8'd9, 8'd4, 8'd3, 1'b0);
    repeat (19) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_state got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
    total++;
    if ({r_out0, r_out1, r_out2, err, sat} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs got=%h exp=0", {r_out0, r_out1, r_out2, err, sat});
    end
    @(negedge clk); rst = 1'b0;
    drive_accept(8'd2, 8'd3, 8'd6, 1'b0);
    wait_valid(lat);
    total++;
    if (lat != LAT) begin bad++; $display("FAIL rst_mid_latency got=%0d exp=%0d", lat, LAT); end
    take_output(obs, ra, va);
    total++;
    if (obs !== {8'd6, 8'd18, 8'd12, 1'b0, 1'b0}) begin
      bad++; $display("FAIL rst_mid_result got=%h exp=%h", obs, {8'd6, 8'd18, 8'd12, 1'b0, 1'b0});
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = 1'b0;
    r_in0 = '0; r_in1 = '0; r_in2 = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
